// File: rtl/mips32_wide_addsub_seq_pkg.sv
// Shared definitions for the wide add/subtract sequencer: FSM state encoding,
// operation codes and a helper that sizes the slice index counter.
package mips32_wide_addsub_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Slice index width; a single-slice build still gets a 1-bit index.
   function automatic int idx_width(input int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/mips32_adder.sv
// Single DATAWIDTH-bit adder slice with carry-in, shared by the wide sequencer.
// Purely combinational; reports carry-out plus zero/overflow/negative flags of
// this slice. Subtraction is done by the caller inverting B and setting cin.
module mips32_adder
   import mips32_wide_addsub_seq_pkg::*;
#(
   parameter int DATAWIDTH = 32
) (
   input  logic [DATAWIDTH-1:0] a_in,
   input  logic [DATAWIDTH-1:0] b_in,
   input  logic                 cin,
   output logic [DATAWIDTH-1:0] o_out,
   output logic                 carry,
   output logic                 zero,
   output logic                 overflow,
   output logic                 negative
);

   logic [DATAWIDTH:0] sum_full;

   assign sum_full = {1'b0, a_in} + {1'b0, b_in} + {{DATAWIDTH{1'b0}}, cin};
   assign o_out    = sum_full[DATAWIDTH-1:0];
   assign carry    = sum_full[DATAWIDTH];
   assign zero     = (o_out == '0);
   assign negative = o_out[DATAWIDTH-1];
   // Signed overflow: operands agree in sign but the result does not.
   assign overflow = (a_in[DATAWIDTH-1] == b_in[DATAWIDTH-1]) &&
                     (o_out[DATAWIDTH-1] != a_in[DATAWIDTH-1]);

endmodule

// File: rtl/mips32_wide_addsub_seq.sv
// Wide (DATAWIDTH*WORDS bit) add/subtract built from one shared adder slice.
// One slice per cycle, least significant first, carry chained through a
// register. Command and result sides use valid/ready handshakes; the result
// is held stable in DONE until the consumer takes it.
module mips32_wide_addsub_seq
   import mips32_wide_addsub_seq_pkg::*;
#(
   parameter int DATAWIDTH = 32,
   parameter int WORDS     = 4
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic                       cmd_sub,
   input  logic [DATAWIDTH*WORDS-1:0] cmd_a,
   input  logic [DATAWIDTH*WORDS-1:0] cmd_b,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [DATAWIDTH*WORDS-1:0] rsp_result,
   output logic                       rsp_zero,
   output logic                       rsp_carry,
   output logic                       rsp_ovf,
   output logic                       rsp_neg,
   output logic                       busy
);

   localparam int W     = DATAWIDTH * WORDS;
   localparam int IDX_W = idx_width(WORDS);
   // Slice mux is padded to a power of two so idx_reg always indexes in range.
   localparam int SLOTS = 2 ** IDX_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   state_t               state_reg, state_next;
   logic [W-1:0]         a_reg, b_reg;
   logic                 sub_reg;
   logic [IDX_W-1:0]     idx_reg;
   logic                 carry_reg;
   logic                 zero_acc_reg;
   logic                 zero_reg, carry_out_reg, ovf_reg, neg_reg;
   logic                 accept, run_step, last_step;

   logic [DATAWIDTH-1:0] a_slice [SLOTS];
   logic [DATAWIDTH-1:0] b_slice [SLOTS];
   logic [DATAWIDTH-1:0] add_a, add_b, add_sum;
   logic                 add_cin, add_carry, add_zero, add_ovf, add_neg;

   genvar gi;

   // Slice k of each operand register; padding slots are never selected.
   for (gi = 0; gi < SLOTS; gi++) begin : g_slice
      if (gi < WORDS) begin : g_used
         assign a_slice[gi] = a_reg[gi*DATAWIDTH +: DATAWIDTH];
         assign b_slice[gi] = b_reg[gi*DATAWIDTH +: DATAWIDTH];
      end else begin : g_pad
         assign a_slice[gi] = '0;
         assign b_slice[gi] = '0;
      end
   end

   assign add_a   = a_slice[idx_reg];
   assign add_b   = (sub_reg == OP_SUB) ? ~b_slice[idx_reg] : b_slice[idx_reg];
   assign add_cin = (idx_reg == '0) ? sub_reg : carry_reg;

   mips32_adder #(.DATAWIDTH(DATAWIDTH)) u_adder (
      .a_in     (add_a),
      .b_in     (add_b),
      .cin      (add_cin),
      .o_out    (add_sum),
      .carry    (add_carry),
      .zero     (add_zero),
      .overflow (add_ovf),
      .negative (add_neg)
   );

   // Next-state and handshake outputs; all outputs decode from state only.
   always_comb begin
      state_next = state_reg;
      cmd_ready  = 1'b0;
      rsp_valid  = 1'b0;
      busy       = 1'b1;
      accept     = 1'b0;
      run_step   = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid) begin
               accept     = 1'b1;
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            run_step = 1'b1;
            if (idx_reg == LAST_IDX) state_next = ST_DONE;
         end
         ST_DONE: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign last_step = run_step && (idx_reg == LAST_IDX);

   // State register.
   always_ff @(posedge clk) begin
      if (!resetn) state_reg <= ST_IDLE;
      else         state_reg <= state_next;
   end

   // Operand capture, slice counter, carry/zero chaining and final flags.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         a_reg         <= '0;
         b_reg         <= '0;
         sub_reg       <= OP_ADD;
         idx_reg       <= '0;
         carry_reg     <= 1'b0;
         zero_acc_reg  <= 1'b0;
         zero_reg      <= 1'b0;
         carry_out_reg <= 1'b0;
         ovf_reg       <= 1'b0;
         neg_reg       <= 1'b0;
      end else begin
         if (accept) begin
            a_reg        <= cmd_a;
            b_reg        <= cmd_b;
            sub_reg      <= cmd_sub;
            idx_reg      <= '0;
            zero_acc_reg <= 1'b1;
         end
         if (run_step) begin
            carry_reg    <= add_carry;
            zero_acc_reg <= zero_acc_reg & add_zero;
            if (!last_step) idx_reg <= idx_reg + 1'b1;
         end
         // The MSB slice sees the already-inverted B, so its flags are the wide flags.
         if (last_step) begin
            zero_reg      <= zero_acc_reg & add_zero;
            carry_out_reg <= add_carry;
            ovf_reg       <= add_ovf;
            neg_reg       <= add_neg;
         end
      end
   end

   // Result register bank: slice k is written on the cycle idx_reg selects it.
   for (gi = 0; gi < WORDS; gi++) begin : g_res
      logic [DATAWIDTH-1:0] slice_reg;
      always_ff @(posedge clk) begin
         if (!resetn)                                  slice_reg <= '0;
         else if (run_step && idx_reg == IDX_W'(gi))  slice_reg <= add_sum;
      end
      assign rsp_result[gi*DATAWIDTH +: DATAWIDTH] = slice_reg;
   end

   assign rsp_zero  = zero_reg;
   assign rsp_carry = carry_out_reg;
   assign rsp_ovf   = ovf_reg;
   assign rsp_neg   = neg_reg;

endmodule

// File: tb/tb_mips32_wide_addsub_seq.sv
// Bench for the wide add/subtract sequencer: a 4-slice instance checked every
// cycle against a wide-arithmetic model, plus directed literal expectations,
// and a 1-slice instance exercised with directed vectors.
module tb_mips32_wide_addsub_seq;
   import mips32_wide_addsub_seq_pkg::*;

   localparam int DW    = 32;
   localparam int WORDS = 4;
   localparam int W     = DW * WORDS;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   logic         cmd_valid, cmd_ready, cmd_sub, rsp_valid, rsp_ready;
   logic [W-1:0] cmd_a, cmd_b, rsp_result;
   logic         rsp_zero, rsp_carry, rsp_ovf, rsp_neg, busy;

   logic          d1_cmd_valid, d1_cmd_ready, d1_cmd_sub, d1_rsp_valid, d1_rsp_ready;
   logic [DW-1:0] d1_cmd_a, d1_cmd_b, d1_rsp_result;
   logic          d1_rsp_zero, d1_rsp_carry, d1_rsp_ovf, d1_rsp_neg, d1_busy;

   mips32_wide_addsub_seq #(.DATAWIDTH(DW), .WORDS(WORDS)) dut (
      .clk(clk), .resetn(resetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sub(cmd_sub),
      .cmd_a(cmd_a), .cmd_b(cmd_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf), .rsp_neg(rsp_neg),
      .busy(busy)
   );

   mips32_wide_addsub_seq #(.DATAWIDTH(DW), .WORDS(1)) dut1 (
      .clk(clk), .resetn(resetn),
      .cmd_valid(d1_cmd_valid), .cmd_ready(d1_cmd_ready), .cmd_sub(d1_cmd_sub),
      .cmd_a(d1_cmd_a), .cmd_b(d1_cmd_b),
      .rsp_valid(d1_rsp_valid), .rsp_ready(d1_rsp_ready), .rsp_result(d1_rsp_result),
      .rsp_zero(d1_rsp_zero), .rsp_carry(d1_rsp_carry), .rsp_ovf(d1_rsp_ovf), .rsp_neg(d1_rsp_neg),
      .busy(d1_busy)
   );

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   // Behavioural model of the 4-slice instance.
   bit           m_busy = 1'b0;
   int           cyc    = 0;
   int           m_due  = 0;
   logic [W-1:0] m_res  = '0;
   logic [3:0]   m_flags = '0;

   // Wide result and {zero, carry, ovf, neg} from plain signed/unsigned arithmetic.
   function automatic logic [W+3:0] model_op(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b);
      logic signed [W:0] sa, sb, exact;
      logic [W:0]        ua;
      logic [W-1:0]      r;
      logic              c, v;
      sa    = {a[W-1], a};
      sb    = {b[W-1], b};
      exact = sub ? (sa - sb) : (sa + sb);
      ua    = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
      r     = ua[W-1:0];
      c     = sub ? ~ua[W] : ua[W];
      v     = (exact[W] != exact[W-1]);
      return {(r == '0), c, v, r[W-1], r};
   endfunction

   // Model tracks one outstanding op: result due WORDS edges after the accept edge.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!resetn) begin
         m_busy <= 1'b0;
      end else if (m_busy) begin
         if (cyc >= m_due && rsp_ready) m_busy <= 1'b0;
      end else if (cmd_valid) begin
         m_busy             <= 1'b1;
         m_due              <= cyc + 1 + WORDS;
         {m_flags, m_res}   <= model_op(cmd_sub, cmd_a, cmd_b);
      end
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h, required 0x%h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   task automatic monitor_cycle();
      bit exp_v;
      exp_v = m_busy && (cyc >= m_due);
      check("mon rsp_valid", W'(rsp_valid), W'(exp_v));
      check("mon cmd_ready", W'(cmd_ready), W'(!m_busy));
      check("mon busy",      W'(busy),      W'(m_busy));
      if (exp_v) begin
         check("mon rsp_result", rsp_result, m_res);
         check("mon rsp_flags",  W'({rsp_zero, rsp_carry, rsp_ovf, rsp_neg}), W'(m_flags));
      end
   endtask

   // One full transaction on the 4-slice instance with literal expectations.
   task automatic do_op(input string name, input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input logic [W-1:0] exp_res, input logic [3:0] exp_flags);
      int tries, edges;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_sub = sub; cmd_a = a; cmd_b = b;
      tries = 0;
      while (!cmd_ready && tries < 20) begin @(negedge clk); tries++; end
      if (!cmd_ready) timeout({name, " accept"});
      @(posedge clk);
      edges = 1;
      @(negedge clk);
      // Junk on the command bus must not disturb the captured operands.
      cmd_valid = 1'b0; cmd_sub = ~sub; cmd_a = ~a; cmd_b = a;
      while (!rsp_valid && edges < 20) begin @(posedge clk); edges++; @(negedge clk); end
      check({name, " latency"}, W'(edges), W'(WORDS + 1));
      check({name, " result"}, rsp_result, exp_res);
      check({name, " flags"}, W'({rsp_zero, rsp_carry, rsp_ovf, rsp_neg}), W'(exp_flags));
      for (int i = 0; i < hold; i++) begin
         rsp_ready = 1'b0;
         cmd_valid = i[0];
         cmd_a     = {W{i[1]}};
         @(negedge clk);
      end
      if (hold > 0) begin
         check({name, " held result"}, rsp_result, exp_res);
         check({name, " held cmd_ready"}, W'(cmd_ready), W'(0));
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check({name, " ready after rsp"}, W'(cmd_ready), W'(1));
   endtask

   // One transaction on the single-slice instance.
   task automatic d1_op(input string name, input logic sub, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] exp_res, input logic [3:0] exp_flags);
      int edges;
      @(negedge clk);
      check({name, " cmd_ready"}, W'(d1_cmd_ready), W'(1));
      d1_cmd_valid = 1'b1; d1_cmd_sub = sub; d1_cmd_a = a; d1_cmd_b = b;
      @(posedge clk);
      edges = 1;
      @(negedge clk);
      d1_cmd_valid = 1'b0; d1_cmd_a = ~a;
      while (!d1_rsp_valid && edges < 20) begin @(posedge clk); edges++; @(negedge clk); end
      check({name, " latency"}, W'(edges), W'(2));
      check({name, " result"}, W'(d1_rsp_result), W'(exp_res));
      check({name, " flags"}, W'({d1_rsp_zero, d1_rsp_carry, d1_rsp_ovf, d1_rsp_neg}), W'(exp_flags));
      d1_rsp_ready = 1'b1;
      @(negedge clk);
      d1_rsp_ready = 1'b0;
      check({name, " idle after rsp"}, W'({d1_busy, d1_rsp_valid}), W'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b0;
      cmd_valid = 1'b0; cmd_sub = OP_ADD; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
      d1_cmd_valid = 1'b0; d1_cmd_sub = OP_ADD; d1_cmd_a = '0; d1_cmd_b = '0; d1_rsp_ready = 1'b0;

      fork
         forever begin
            @(negedge clk);
            if (chk_en) monitor_cycle();
         end
      join_none

      repeat (2) @(negedge clk);
      resetn = 1'b1;
      check("reset rsp_valid", W'(rsp_valid), W'(0));
      check("reset cmd_ready", W'(cmd_ready), W'(1));
      check("reset busy", W'(busy), W'(0));
      check("reset result", rsp_result, W'(0));
      check("reset flags", W'({rsp_zero, rsp_carry, rsp_ovf, rsp_neg}), W'(0));
      chk_en = 1'b1;

      do_op("add carry chain", OP_ADD,
            128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h1, 0,
            128'h0000_0001_0000_0000_0000_0000_0000_0000, 4'b0000);
      do_op("sub equal", OP_SUB,
            128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321,
            128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 0,
            128'h0, 4'b1100);
      do_op("add signed ovf", OP_ADD,
            128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h1, 0,
            128'h8000_0000_0000_0000_0000_0000_0000_0000, 4'b0011);
      do_op("sub borrow", OP_SUB, 128'h0, 128'h1, 0, {W{1'b1}}, 4'b0001);
      do_op("backpressure", OP_ADD, {W{1'b1}}, {W{1'b1}}, 6,
            {{(W-1){1'b1}}, 1'b0}, 4'b0101);
      do_op("sub min minus one", OP_SUB,
            128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'h1, 0,
            128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 4'b0110);

      // Abort mid-RUN at slice 2 with a carry in flight.
      @(negedge clk);
      cmd_valid = 1'b1; cmd_sub = OP_ADD; cmd_a = {W{1'b1}}; cmd_b = 128'h1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      check("abort rsp_valid", W'(rsp_valid), W'(0));
      check("abort result", rsp_result, W'(0));
      check("abort cmd_ready", W'(cmd_ready), W'(1));
      check("abort busy", W'(busy), W'(0));
      do_op("after abort", OP_ADD,
            128'h0000_0000_0000_0000_FFFF_FFFF_0000_0005, 128'h7, 0,
            128'h0000_0000_0000_0000_FFFF_FFFF_0000_000C, 4'b0000);

      d1_op("w1 add wrap", OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b1100);
      d1_op("w1 sub neg", OP_SUB, 32'h3, 32'h5, 32'hFFFF_FFFE, 4'b0001);
      d1_op("w1 add ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b0011);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
